sobel_window_core: RTL and testbench
====================================

Name: sobel_window_core

Overview:
Downstream stage of the grayscale converter. Consumes the 8-bit gray pixel stream and its px_rdy strobe, assembles a sliding 3x3 window from column-ordered pixels, and computes the Sobel gradient magnitude |Gx|+|Gy|, saturated to 8 bits. Emits one result per completed column once the window is primed, through a 2-stage pipeline.

Parameters:
PIXEL_WIDTH_OUT, 8, gray input and magnitude output width (matches the gray stage output width).

Ports:
clk_i  input  1  clock
nreset_i  input  1  asynchronous active-low reset
start_i  input  1  synchronous frame/strip restart; clears fill state
px_rdy_i  input  1  input pixel valid strobe, one pixel per asserted cycle
in_px_gray_i  input  PIXEL_WIDTH_OUT  gray pixel
out_px_sobel_o  output  PIXEL_WIDTH_OUT  gradient magnitude
px_rdy_o  output  1  single-cycle result valid pulse
win_valid_o  output  1  high once 3 full columns are held

Behaviour:
- Reset: nreset_i is asynchronous, active-low; clock is clk_i. On reset, out_px_sobel_o=0, px_rdy_o=0, win_valid_o=0, row counter=0, column fill count=0, window registers=0, pipeline valids=0.
- Input order: column-major, top->bottom. Each column is 3 pixels (rows 0,1,2). Row counter (2 bits) advances 0->1->2->0 on each px_rdy_i.
- Column buffer: pixels for rows 0 and 1 are held in a staging register. On the row-2 pixel, the completed column shifts into the window: C0<=C1, C1<=C2, C2<=new column. C0 is the oldest/left column; C2 is the newest/right column.
- Fill count: saturates at 3 and increments on each column completion. win_valid_o = (fill==3), registered.
- Compute trigger: column completes AND fill is already >=2 before the shift (i.e. the window is full after the shift).
- Stage 1 (cycle after the trigger): register Gx and Gy, signed, 11 bits each.
  - Gx = (C2r0 + 2*C2r1 + C2r2) - (C0r0 + 2*C0r1 + C0r2).
  - Gy = (C0r2 + 2*C1r2 + C2r2) - (C0r0 + 2*C1r0 + C2r0).
  - Weighted sums are 10-bit unsigned (max 1020).
- Stage 2: mag = |Gx|+|Gy| (12-bit unsigned, max 2040). out_px_sobel_o = min(mag, 255). px_rdy_o pulses for exactly 1 cycle.
- Latency: px_rdy_o is asserted 2 cycles after the px_rdy_i edge that captured the triggering row-2 pixel.
- out_px_sobel_o holds its last value when px_rdy_o=0.
- Throughput: one pixel per cycle sustained, giving one result per 3 input pixels. Gaps in px_rdy_i are allowed; state is held across gaps.
- First 8 pixels after reset or start_i produce no px_rdy_o.
- start_i:
  - Clears the row counter and fill count. Window data is not cleared; it is don't-care.
  - Results already in the pipeline still complete.
  - If start_i and px_rdy_i are asserted in the same cycle, the clear happens first and that pixel is row 0 of column 0 of the new strip.
- start_i mid-column: the partial column is discarded.
- Reset mid-operation: everything returns to reset values immediately, including in-flight pipeline results; no pulse is emitted.

Optional Feature:
- Macro SOBEL_THRESHOLD_EN.
- Defined:
  - Adds input port threshold_i (PIXEL_WIDTH_OUT bits).
  - Stage 2 output = 8'hFF if saturated mag >= threshold_i, else 8'h00 (binary edge map).
  - threshold_i is sampled in stage 2.
- Undefined: no threshold_i port; output is the saturated magnitude.

Test Plan:
- Flat field: 12 pixels all 100 -> 2 px_rdy_o pulses, each out_px_sobel_o=0; no pulse during the first 8 pixels; win_valid_o rises after pixel 9.
- Vertical edge: C0=C1=(0,0,0), C2=(10,10,10) -> Gx=40, Gy=0, out=40 exactly 2 cycles after pixel 9. Then a 4th column (10,10,10) -> window (0,10,10) columns -> out=40.
- Horizontal edge: all 3 columns (0,0,10) -> Gy=40, Gx=0, out=40. Columns (0,0,255) -> Gy=1020 -> out=255 (saturation).
- Diagonal/abs: C0=(255,255,255), C1=(0,0,0), C2=(0,0,0) -> Gx=-1020 -> out=255. C0=(20,0,0), others 0 -> Gx=-20, Gy=-20 -> out=40.
- Control: start_i asserted after 5 pixels, with a pixel in the same cycle -> that pixel counts as the new row 0. The next pulse comes only after 8 further pixels.
- Reset: nreset_i asserted 1 cycle after a trigger -> no px_rdy_o, all outputs 0. Random px_rdy_i gaps yield identical results to back-to-back input.
- With SOBEL_THRESHOLD_EN: threshold_i=40 with the vertical-edge case -> out=FF; threshold_i=41 -> out=00.

Source files
------------

// File: rtl/sobel_window_core.sv
// Sobel 3x3 gradient stage: column-major gray pixels in, |Gx|+|Gy| saturated out.
// Optional macro SOBEL_THRESHOLD_EN adds threshold_i and emits a binary edge map.
module sobel_window_core #(
  parameter int PIXEL_WIDTH_OUT = 8
) (
  input  logic                       clk_i,
  input  logic                       nreset_i,
  input  logic                       start_i,
  input  logic                       px_rdy_i,
  input  logic [PIXEL_WIDTH_OUT-1:0] in_px_gray_i,
`ifdef SOBEL_THRESHOLD_EN
  input  logic [PIXEL_WIDTH_OUT-1:0] threshold_i,
`endif
  output logic [PIXEL_WIDTH_OUT-1:0] out_px_sobel_o,
  output logic                       px_rdy_o,
  output logic                       win_valid_o
);

  localparam int PW = PIXEL_WIDTH_OUT;
  localparam int SW = PW + 2;  // weighted column/row sum
  localparam int GW = PW + 3;  // signed gradient
  localparam int MW = PW + 4;  // |Gx|+|Gy|

  logic [1:0]           row, fill;
  logic [PW-1:0]        stage0, stage1;
  logic [2:0][PW-1:0]   col0, col1, col2;  // col0 oldest (left), col2 newest (right)
  logic                 trig_q, s1_valid;
  logic signed [GW-1:0] gx, gy;

  logic [1:0]           row_eff, fill_eff;
  logic                 col_done, trig;
  logic [SW-1:0]        sum_l, sum_r, sum_t, sum_b;
  logic signed [GW-1:0] gx_c, gy_c;
  logic [GW-1:0]        abs_x, abs_y;
  logic [MW-1:0]        mag;
  logic [PW-1:0]        sat;

  function automatic logic [SW-1:0] wsum(input logic [PW-1:0] a, b, c);
    return SW'(a) + (SW'(b) << 1) + SW'(c);
  endfunction

  // NOTE: every signal assigned in this block gets a value on every path, so no latch is inferred.
  always_comb begin
    // A same-cycle start clears the strip before the incoming pixel is placed.
    row_eff  = start_i ? 2'd0 : row;
    fill_eff = start_i ? 2'd0 : fill;
    col_done = px_rdy_i && (row_eff == 2'd2);
    trig     = col_done && (fill_eff >= 2'd2);

    sum_r = wsum(col2[0], col2[1], col2[2]);
    sum_l = wsum(col0[0], col0[1], col0[2]);
    sum_b = wsum(col0[2], col1[2], col2[2]);
    sum_t = wsum(col0[0], col1[0], col2[0]);
    gx_c  = $signed(GW'(sum_r)) - $signed(GW'(sum_l));
    gy_c  = $signed(GW'(sum_b)) - $signed(GW'(sum_t));

    abs_x = gx[GW-1] ? $unsigned(-gx) : $unsigned(gx);
    abs_y = gy[GW-1] ? $unsigned(-gy) : $unsigned(gy);
    mag   = MW'(abs_x) + MW'(abs_y);
    sat   = (mag > MW'({PW{1'b1}})) ? {PW{1'b1}} : mag[PW-1:0];
  end

  assign win_valid_o = (fill == 2'd3);

  // NOTE: state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk_i or negedge nreset_i) begin
    if (!nreset_i) begin
      row            <= '0;
      fill           <= '0;
      stage0         <= '0;
      stage1         <= '0;
      // NOTE: the window is only a few registers, so it is reset along with the control state.
      col0           <= '0;
      col1           <= '0;
      col2           <= '0;
      trig_q         <= 1'b0;
      s1_valid       <= 1'b0;
      gx             <= '0;
      gy             <= '0;
      px_rdy_o       <= 1'b0;
      out_px_sobel_o <= '0;
    end else begin
      if (start_i) begin
        row  <= 2'd0;
        fill <= 2'd0;
      end
      if (px_rdy_i) begin
        row <= (row_eff == 2'd2) ? 2'd0 : row_eff + 2'd1;
        if (row_eff == 2'd0) stage0 <= in_px_gray_i;
        if (row_eff == 2'd1) stage1 <= in_px_gray_i;
        if (col_done) begin
          col0 <= col1;
          col1 <= col2;
          col2 <= {in_px_gray_i, stage1, stage0};
          fill <= (fill_eff == 2'd3) ? 2'd3 : fill_eff + 2'd1;
        end
      end

      // Window is stable for the two cycles after a column lands, so stage 1 reads it directly.
      trig_q   <= trig;
      s1_valid <= trig_q;
      if (trig_q) begin
        gx <= gx_c;
        gy <= gy_c;
      end

      px_rdy_o <= s1_valid;
      if (s1_valid) begin
`ifdef SOBEL_THRESHOLD_EN
        out_px_sobel_o <= (sat >= threshold_i) ? {PW{1'b1}} : {PW{1'b0}};
`else
        out_px_sobel_o <= sat;
`endif
      end
    end
  end

endmodule

// File: tb/tb_sobel_window_core.sv
// Self-checking bench for sobel_window_core: directed literal cases plus a
// column-list reference model compared on every cycle under random stimulus.
module tb_sobel_window_core;

  logic       clk = 1'b0;
  logic       nreset = 1'b0;
  logic       start_i = 1'b0;
  logic       px_rdy_i = 1'b0;
  logic [7:0] in_px = '0;
  logic [7:0] out_px;
  logic       px_rdy_o;
  logic       win_valid;
`ifdef SOBEL_THRESHOLD_EN
  logic [7:0] threshold = 8'd40;
`endif

  sobel_window_core #(.PIXEL_WIDTH_OUT(8)) dut (
    .clk_i          (clk),
    .nreset_i       (nreset),
    .start_i        (start_i),
    .px_rdy_i       (px_rdy_i),
    .in_px_gray_i   (in_px),
`ifdef SOBEL_THRESHOLD_EN
    .threshold_i    (threshold),
`endif
    .out_px_sobel_o (out_px),
    .px_rdy_o       (px_rdy_o),
    .win_valid_o    (win_valid)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  task automatic check(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Expected output for a given saturated magnitude.
  function automatic int tval(input int m);
`ifdef SOBEL_THRESHOLD_EN
    return (m >= int'(threshold)) ? 255 : 0;
`else
    return m;
`endif
  endfunction

  // Reference model: the strip is a list of completed columns; every column
  // that makes three available yields one result two cycles later.
  typedef struct {int due; int val;} exp_t;
  exp_t exp_q[$];
  int   m_row = 0, m_fill = 0, cyc = 0, m_last = 0;
  int   m_col[3];
  int   m_win[3][3];   // [column][row], column 0 oldest
  int   got[$];        // every DUT result, in order

  function automatic int sobel_ref();
    int gx, gy, mag;
    gx  = (m_win[2][0] + 2*m_win[2][1] + m_win[2][2]) - (m_win[0][0] + 2*m_win[0][1] + m_win[0][2]);
    gy  = (m_win[0][2] + 2*m_win[1][2] + m_win[2][2]) - (m_win[0][0] + 2*m_win[1][0] + m_win[2][0]);
    mag = (gx < 0 ? -gx : gx) + (gy < 0 ? -gy : gy);
    return mag > 255 ? 255 : mag;
  endfunction

  always begin
    @(posedge clk or negedge nreset);
    cyc++;
    if (!nreset) begin
      m_row = 0; m_fill = 0; m_last = 0;
      exp_q.delete();
    end else begin
      if (start_i) begin m_row = 0; m_fill = 0; end
      if (px_rdy_i) begin
        m_col[m_row] = int'(in_px);
        if (m_row == 2) begin
          for (int c = 0; c < 2; c++)
            for (int r = 0; r < 3; r++) m_win[c][r] = m_win[c+1][r];
          for (int r = 0; r < 3; r++) m_win[2][r] = m_col[r];
          m_fill = (m_fill == 3) ? 3 : m_fill + 1;
          if (m_fill == 3) exp_q.push_back('{due: cyc + 2, val: sobel_ref()});
        end
        m_row = (m_row == 2) ? 0 : m_row + 1;
      end
    end
    if (clk) begin
      bit due;
      #1;
      due = (exp_q.size() > 0) && (exp_q[0].due == cyc);
      if (due) begin
        m_last = tval(exp_q[0].val);
        void'(exp_q.pop_front());
      end
      check("px_rdy_o", int'(px_rdy_o), int'(due));
      check("out_px_sobel_o", int'(out_px), m_last);
      check("win_valid_o", int'(win_valid), int'(m_fill == 3));
      if (px_rdy_o) got.push_back(int'(out_px));
    end
  end

  task automatic send_px(input int v, input bit s);
    @(negedge clk);
    px_rdy_i = 1'b1;
    start_i  = s;
    in_px    = 8'(v);
  endtask

  task automatic send_col(input int a, input int b, input int c);
    send_px(a, 0); send_px(b, 0); send_px(c, 0);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      px_rdy_i = 1'b0;
      start_i  = 1'b0;
    end
  endtask

  task automatic start_strip();
    @(negedge clk);
    px_rdy_i = 1'b0;
    start_i  = 1'b1;
    @(negedge clk);
    start_i  = 1'b0;
  endtask

  // Waits a bounded time for the pulse following the last sent pixel.
  task automatic wait_pulse(input string name, input int exp_mag);
    int n = 0;
    bit seen = 0;
    @(negedge clk);
    px_rdy_i = 1'b0;
    start_i  = 1'b0;
    while (!seen && n < 8) begin
      @(posedge clk);
      #1;
      n++;
      if (px_rdy_o) seen = 1;
    end
    check({name, " pulse seen"}, int'(seen), 1);
    check({name, " latency"}, n, 2);
    check(name, int'(out_px), tval(exp_mag));
  endtask

  int cols[6][3];
  int ref_res[$];

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    repeat (3) @(negedge clk);
    nreset = 1'b1;
    check("reset out", int'(out_px), 0);
    check("reset px_rdy", int'(px_rdy_o), 0);
    check("reset win_valid", int'(win_valid), 0);

    // Flat field: 12 equal pixels give two zero results.
    got.delete();
    for (int i = 1; i <= 12; i++) begin
      send_px(100, 0);
      @(posedge clk);
      #1;
      if (i == 8) check("flat win_valid after 8", int'(win_valid), 0);
      if (i == 9) check("flat win_valid after 9", int'(win_valid), 1);
    end
    idle(6);
    check("flat pulse count", got.size(), 2);
    if (got.size() == 2) begin
      check("flat result 0", got[0], tval(0));
      check("flat result 1", got[1], tval(0));
    end

    // Vertical edge, then one more bright column.
    start_strip();
    send_col(0, 0, 0); send_col(0, 0, 0); send_col(10, 10, 10);
    wait_pulse("vedge", 40);
    send_col(10, 10, 10);
    wait_pulse("vedge col4", 40);

    // Horizontal edge and saturation.
    start_strip();
    send_col(0, 0, 10); send_col(0, 0, 10); send_col(0, 0, 10);
    wait_pulse("hedge", 40);
    start_strip();
    send_col(0, 0, 255); send_col(0, 0, 255); send_col(0, 0, 255);
    wait_pulse("hedge sat", 255);

    // Negative gradients.
    start_strip();
    send_col(255, 255, 255); send_col(0, 0, 0); send_col(0, 0, 0);
    wait_pulse("neg gx sat", 255);
    start_strip();
    send_col(20, 0, 0); send_col(0, 0, 0); send_col(0, 0, 0);
    wait_pulse("diag abs", 40);

    // start_i with a pixel in the same cycle: that pixel is row 0 of column 0.
    start_strip();
    for (int i = 0; i < 5; i++) send_px(200, 0);
    got.delete();
    send_px(0, 1);
    send_px(0, 0); send_px(0, 0);
    send_col(0, 0, 0);
    send_px(30, 0); send_px(30, 0);
    idle(5);
    check("ctl no early pulse", got.size(), 0);
    send_px(30, 0);
    wait_pulse("ctl after restart", 120);

    // Reset one cycle after a trigger: the in-flight result is dropped.
    start_strip();
    got.delete();
    send_col(9, 80, 7); send_col(1, 2, 3); send_col(200, 100, 50);
    @(negedge clk);
    px_rdy_i = 1'b0;
    nreset   = 1'b0;
    repeat (4) begin
      @(posedge clk);
      #1;
      check("rst px_rdy", int'(px_rdy_o), 0);
      check("rst out", int'(out_px), 0);
      check("rst win_valid", int'(win_valid), 0);
    end
    @(negedge clk);
    nreset = 1'b1;
    check("rst no result", got.size(), 0);

    // Same columns back-to-back and with gaps must give identical results.
    for (int c = 0; c < 6; c++)
      for (int r = 0; r < 3; r++) cols[c][r] = int'($urandom_range(0, 255));
    start_strip();
    got.delete();
    for (int c = 0; c < 6; c++) send_col(cols[c][0], cols[c][1], cols[c][2]);
    idle(6);
    ref_res = got;
    check("b2b result count", ref_res.size(), 4);
    start_strip();
    got.delete();
    for (int c = 0; c < 6; c++)
      for (int r = 0; r < 3; r++) begin
        if ($urandom_range(0, 2) == 0) idle(int'($urandom_range(1, 3)));
        send_px(cols[c][r], 0);
      end
    idle(6);
    check("gap result count", got.size(), ref_res.size());
    for (int i = 0; i < got.size() && i < ref_res.size(); i++)
      check("gap result", got[i], ref_res[i]);

    // Random stream with gaps and occasional restarts.
    for (int i = 0; i < 600; i++) begin
      int k = int'($urandom_range(0, 99));
      int v = ($urandom_range(0, 3) == 0) ? 255 : int'($urandom_range(0, 255));
      if (k < 2) send_px(v, 1);
      else if (k < 4) start_strip();
      else if (k < 25) idle(1);
      else send_px(v, 0);
    end
    idle(6);

`ifdef SOBEL_THRESHOLD_EN
    threshold = 8'd40;
    start_strip();
    send_col(0, 0, 0); send_col(0, 0, 0); send_col(10, 10, 10);
    wait_pulse("thr 40", 40);
    check("thr 40 literal", int'(out_px), 255);
    threshold = 8'd41;
    start_strip();
    send_col(0, 0, 0); send_col(0, 0, 0); send_col(10, 10, 10);
    wait_pulse("thr 41", 40);
    check("thr 41 literal", int'(out_px), 0);
    idle(4);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
